// File: rtl/gray_codec_pipe_if.sv
// Valid/ready bus for gray_codec_pipe: input word plus mode, output word plus mode.
// out_parity exists only when GRAY_CODEC_PARITY_EN is defined.
interface gray_codec_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [WIDTH-1:0] out_data;

`ifdef GRAY_CODEC_PARITY_EN
  logic             out_parity;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data, out_parity
  );
  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data, out_parity
  );
`else
  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data
  );
  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data
  );
`endif
endinterface

// File: rtl/gray_codec_pipe.sv
// Pipelined binary<->Gray converter with valid/ready flow control, mode chosen per word.
// Define GRAY_CODEC_PARITY_EN to add a registered out_parity output.
module gray_codec_pipe #(
  parameter int WIDTH = 8,
  parameter int PIPE  = 2
) (
  input logic              clk,
  input logic              rst,
  gray_codec_pipe_if.slave bus
);
  localparam int CH = (WIDTH + PIPE - 1) / PIPE;

  logic [PIPE-1:0]  v_q;
  logic [PIPE-1:0]  v_d;
  logic [PIPE-1:0]  adv;
  logic [PIPE-1:0]  load;
  logic [PIPE:0]    src_v;
  logic [WIDTH-1:0] data_q [PIPE];
  logic             mode_q [PIPE];

  // Advance chain runs from the sink back to stage 1, so a full pipe still moves.
  always_comb begin
    logic chain;
    adv   = '0;
    chain = bus.out_ready;
    for (int k = PIPE - 1; k >= 0; k--) begin
      adv[k] = !v_q[k] || chain;
      chain  = adv[k];
    end
  end

  always_comb begin
    src_v = {v_q, bus.in_valid};
    v_d   = v_q;
    load  = '0;
    for (int k = 0; k < PIPE; k++) begin
      if (adv[k]) begin
        v_d[k]  = src_v[k];
        load[k] = src_v[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  assign bus.in_ready  = !rst && adv[0];
  assign bus.out_valid = v_q[PIPE-1];
  assign bus.out_data  = data_q[PIPE-1];
  assign bus.out_mode  = mode_q[PIPE-1];

`ifdef GRAY_CODEC_PARITY_EN
  logic parity_q;
  assign bus.out_parity = parity_q;
`endif

  for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
    // Chunk of bits this stage resolves in Gray->binary mode; HI < 0 means an empty chunk.
    localparam int HI     = WIDTH - 1 - gi * CH;
    localparam int LO_RAW = WIDTH - (gi + 1) * CH;
    localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;

    logic [WIDTH-1:0] src_data;
    logic             src_mode;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] data_d;
    logic             mode_d;

    if (gi == 0) begin : g_first
      assign src_data = bus.in_data;
      assign src_mode = bus.in_mode;
    end else begin : g_next
      assign src_data = data_q[gi-1];
      assign src_mode = mode_q[gi-1];
    end

    // Bits above HI are already binary; the lowest of them seeds the running XOR.
    always_comb begin
      logic run;
      res = src_data;
      run = 1'b0;
      if (src_mode) begin
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (i > HI) begin
            run = src_data[i];
          end else if (i >= LO) begin
            run    = run ^ src_data[i];
            res[i] = run;
          end
        end
      end else if (gi == 0) begin
        res = src_data ^ (src_data >> 1);
      end
    end

    always_comb begin
      data_d = data_q[gi];
      mode_d = mode_q[gi];
      if (load[gi]) begin
        data_d = res;
        mode_d = src_mode;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q[gi] <= '0;
        mode_q[gi] <= 1'b0;
      end else begin
        data_q[gi] <= data_d;
        mode_q[gi] <= mode_d;
      end
    end

`ifdef GRAY_CODEC_PARITY_EN
    if (gi == PIPE - 1) begin : g_parity
      logic parity_d;

      always_comb begin
        parity_d = parity_q;
        if (load[gi]) begin
          parity_d = ^res;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          parity_q <= 1'b0;
        end else begin
          parity_q <= parity_d;
        end
      end
    end
`endif
  end
endmodule
